// File: rtl/data_sram_ctrl_pkg.sv
// Data SRAM controller: shared ALU op defines, FSM state type,
// byte-enable decode and store-data format helpers.
`ifndef DATA_SRAM_CTRL_DEFINES
`define DATA_SRAM_CTRL_DEFINES
`define ALU_OP_BUS    7:0
`define SRAM_BSEL_BUS 3:0
`define SRAM_DATA_BUS 31:0
`define EXE_LB_OP     8'h24
`define EXE_LW_OP     8'h25
`define EXE_SB_OP     8'h28
`define EXE_SW_OP     8'h29
`endif

package data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // Active-low lane mask: bytes only touch one lane, words all four.
  function automatic logic [3:0] be_decode(
    input logic [`ALU_OP_BUS] op,
    input logic [1:0]         lo
  );
    logic [3:0] m;
    m = 4'b0000;
    if (op == `EXE_LB_OP || op == `EXE_SB_OP) begin
      m = ~(4'b0001 << lo);
    end
    return m;
  endfunction

  // Byte stores replicate the byte so any lane sees it.
  function automatic logic [31:0] fmt_wdata(
    input logic [`ALU_OP_BUS] op,
    input logic [31:0]        wd
  );
    logic [31:0] d;
    d = wd;
    if (op == `EXE_SB_OP) begin
      d = {4{wd[7:0]}};
    end
    return d;
  endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-side SRAM access FSM with WAIT_CYCLES wait states.
// Ports: CLK/RST, EX/MEM request in, SRAM pins, MEM-stage result, STALL_REQ.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [`ALU_OP_BUS]    ALU_OP,
  input  logic [31:0]           ADDR,
  input  logic [31:0]           WDATA,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic [3:0]            SRAM_BE_N,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic [31:0]           SRAM_DOUT,
  output logic                  SRAM_DOUT_EN,
  input  logic [31:0]           SRAM_DIN,
  output logic [`SRAM_BSEL_BUS] SRAM_BE,
  output logic [`SRAM_DATA_BUS] SRAM_RDATA,
  output logic                  DONE,
  output logic                  ADDR_ERR,
  output logic                  STALL_REQ
);

  localparam logic [3:0] LAST    = 4'(WAIT_CYCLES);
  localparam logic [3:0] WE_LAST = 4'(WAIT_CYCLES - 1);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic ld_q, ld_n;
  logic ce_nx, oe_nx, we_nx, den_nx;
  logic [3:0] ben_nx, be_nx, be_dec;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0] dout_nx, rdata_nx;
  logic done_nx, err_nx;
  logic is_ld, is_st, is_mem, misal;
  logic unused_addr;

  assign unused_addr = ^ADDR[31:ADDR_W+2];

  assign is_ld  = ALU_OP == `EXE_LB_OP ||
                  ALU_OP == `EXE_LW_OP;
  assign is_st  = ALU_OP == `EXE_SB_OP ||
                  ALU_OP == `EXE_SW_OP;
  assign is_mem = is_ld || is_st;
  assign misal  = (ALU_OP == `EXE_LW_OP ||
                   ALU_OP == `EXE_SW_OP) &&
                  ADDR[1:0] != 2'b00;
  assign be_dec = be_decode(ALU_OP, ADDR[1:0]);

  assign STALL_REQ = !RST &&
    ((state == ST_IDLE && REQ_VALID && is_mem) ||
     state == ST_ACCESS);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ld_n     = ld_q;
    ce_nx    = SRAM_CE_N;
    oe_nx    = SRAM_OE_N;
    we_nx    = SRAM_WE_N;
    den_nx   = SRAM_DOUT_EN;
    ben_nx   = SRAM_BE_N;
    be_nx    = SRAM_BE;
    addr_nx  = SRAM_ADDR;
    dout_nx  = SRAM_DOUT;
    rdata_nx = SRAM_RDATA;
    done_nx  = 1'b0;
    err_nx   = ADDR_ERR;
    unique case (state)
      ST_IDLE: begin
        if (REQ_VALID && is_mem) begin
          if (misal) begin
            state_n = ST_DONE;
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end else begin
            state_n = ST_ACCESS;
            cnt_n   = 4'd0;
            ld_n    = is_ld;
            addr_nx = ADDR[ADDR_W+1:2];
            ben_nx  = be_dec;
            be_nx   = be_dec;
            ce_nx   = 1'b0;
            oe_nx   = !is_ld;
            we_nx   = is_ld;
            den_nx  = !is_ld;
            if (!is_ld) begin
              dout_nx = fmt_wdata(ALU_OP, WDATA);
            end
          end
        end
      end
      ST_ACCESS: begin
        cnt_n = cnt + 4'd1;
        // WE_N rises one cycle early for addr/data hold.
        if (cnt == WE_LAST) begin
          we_nx = 1'b1;
        end
        if (cnt == LAST) begin
          state_n = ST_DONE;
          done_nx = 1'b1;
          ce_nx   = 1'b1;
          oe_nx   = 1'b1;
          we_nx   = 1'b1;
          den_nx  = 1'b0;
          ben_nx  = 4'b1111;
          if (ld_q) begin
            rdata_nx = SRAM_DIN;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        err_nx  = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      ld_q         <= 1'b0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      SRAM_BE_N    <= 4'b1111;
      SRAM_ADDR    <= '0;
      SRAM_DOUT    <= '0;
      SRAM_DOUT_EN <= 1'b0;
      SRAM_BE      <= 4'b1111;
      SRAM_RDATA   <= '0;
      DONE         <= 1'b0;
      ADDR_ERR     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ld_q         <= ld_n;
      SRAM_CE_N    <= ce_nx;
      SRAM_OE_N    <= oe_nx;
      SRAM_WE_N    <= we_nx;
      SRAM_BE_N    <= ben_nx;
      SRAM_ADDR    <= addr_nx;
      SRAM_DOUT    <= dout_nx;
      SRAM_DOUT_EN <= den_nx;
      SRAM_BE      <= be_nx;
      SRAM_RDATA   <= rdata_nx;
      DONE         <= done_nx;
      ADDR_ERR     <= err_nx;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl, WAIT_CYCLES=1 and =3.
// Two instances share one stimulus stream.
module tb_data_sram_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic REQ_VALID;
  logic [7:0] ALU_OP;
  logic [31:0] ADDR, WDATA, SRAM_DIN;

  logic ce1, oe1, we1, den1, done1, err1, stall1;
  logic [3:0] ben1, be1;
  logic [19:0] addr1;
  logic [31:0] dout1, rdata1;

  logic ce3, oe3, we3, den3, done3, err3, stall3;
  logic [3:0] ben3, be3;
  logic [19:0] addr3;
  logic [31:0] dout3, rdata3;

  int tests = 0;
  int fails = 0;

  int lat, n_oe, n_we, n_den, n_ce, n_stall;
  logic [3:0] ben_seen;
  logic [19:0] addr_seen;
  logic [31:0] dout_seen;
  logic err_seen, stall_done, err_after, done_after;

  always #5 CLK = ~CLK;

  data_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(20)) u1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID),
    .ALU_OP(ALU_OP), .ADDR(ADDR), .WDATA(WDATA),
    .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
    .SRAM_BE_N(ben1), .SRAM_ADDR(addr1),
    .SRAM_DOUT(dout1), .SRAM_DOUT_EN(den1),
    .SRAM_DIN(SRAM_DIN), .SRAM_BE(be1),
    .SRAM_RDATA(rdata1), .DONE(done1),
    .ADDR_ERR(err1), .STALL_REQ(stall1)
  );

  data_sram_ctrl #(.WAIT_CYCLES(3), .ADDR_W(20)) u3 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID),
    .ALU_OP(ALU_OP), .ADDR(ADDR), .WDATA(WDATA),
    .SRAM_CE_N(ce3), .SRAM_OE_N(oe3), .SRAM_WE_N(we3),
    .SRAM_BE_N(ben3), .SRAM_ADDR(addr3),
    .SRAM_DOUT(dout3), .SRAM_DOUT_EN(den3),
    .SRAM_DIN(SRAM_DIN), .SRAM_BE(be3),
    .SRAM_RDATA(rdata3), .DONE(done3),
    .ADDR_ERR(err3), .STALL_REQ(stall3)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Issues one request to u1 and profiles its pins until DONE.
  task automatic run_access(
    input logic [7:0]  op,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    ALU_OP = op; ADDR = a; WDATA = wd;
    REQ_VALID = 1'b1;
    #1;
    lat = -1; n_oe = 0; n_we = 0; n_den = 0; n_ce = 0;
    n_stall = stall1 ? 1 : 0;
    ben_seen = 4'hx; addr_seen = 'x; dout_seen = 'x;
    err_seen = 1'bx; stall_done = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #2;
      REQ_VALID = 1'b0;
      if (!ce1) begin
        n_ce++; ben_seen = ben1; addr_seen = addr1;
      end
      if (!oe1) n_oe++;
      if (!we1) n_we++;
      if (den1) begin
        n_den++; dout_seen = dout1;
      end
      if (done1) begin
        lat = k; err_seen = err1; stall_done = stall1;
        break;
      end
      if (stall1) n_stall++;
    end
    check("done_timeout", 32'(lat != -1), 1);
    @(posedge CLK); #2;
    err_after = err1; done_after = done1;
  endtask

  int dq[$];
  int ndone;

  initial begin
    RST = 1'b1; REQ_VALID = 1'b1; ALU_OP = `EXE_LW_OP;
    ADDR = 32'h10; WDATA = 0; SRAM_DIN = 0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_stall", 32'(stall1), 0);
    check("rst_pins", {ce1, oe1, we1, den1}, 4'b1110);
    check("rst_be_n", ben1, 4'hf);
    check("rst_be", be1, 4'hf);
    check("rst_addr", addr1, 0);
    check("rst_dout", dout1, 0);
    check("rst_rdata", rdata1, 0);
    check("rst_done_err", {done1, err1}, 0);
    REQ_VALID = 1'b0; RST = 1'b0;
    idle(2);

    ALU_OP = 8'h01; REQ_VALID = 1'b1; #1;
    check("nonmem_stall", 32'(stall1), 0);
    idle(3);
    check("nonmem_ce", 32'(ce1), 1);

    SRAM_DIN = 32'hDEADBEEF;
    run_access(`EXE_LW_OP, 32'h0000_0010, 0);
    check("lw_lat", lat, 3);
    check("lw_oe", n_oe, 2);
    check("lw_ce", n_ce, 2);
    check("lw_we", n_we, 0);
    check("lw_den", n_den, 0);
    check("lw_stall", n_stall, 3);
    check("lw_stall_done", 32'(stall_done), 0);
    check("lw_addr", addr_seen, 4);
    check("lw_be_n", ben_seen, 4'h0);
    check("lw_rdata", rdata1, 32'hDEADBEEF);
    check("lw_be", be1, 4'h0);
    check("lw_err", 32'(err_seen), 0);
    check("lw_pulse", 32'(done_after), 0);
    check("lw_idle_pins", {ce1, oe1, we1}, 3'b111);
    idle(4);

    SRAM_DIN = 32'h11223344;
    run_access(`EXE_LB_OP, 32'h0000_0103, 0);
    check("lb3_be_n", ben_seen, 4'h7);
    check("lb3_be", be1, 4'h7);
    check("lb3_addr", addr_seen, 20'h40);
    check("lb3_rdata", rdata1, 32'h11223344);
    idle(4);

    SRAM_DIN = 32'h55667788;
    run_access(`EXE_LB_OP, 32'h0000_0101, 0);
    check("lb1_be_n", ben_seen, 4'hd);
    check("lb1_be", be1, 4'hd);
    idle(4);

    SRAM_DIN = 32'h99999999;
    run_access(`EXE_SB_OP, 32'h0000_0202, 32'h0000_00A5);
    check("sb_dout", dout_seen, 32'hA5A5A5A5);
    check("sb_be_n", ben_seen, 4'hb);
    check("sb_we", n_we, 1);
    check("sb_den", n_den, 2);
    check("sb_oe", n_oe, 0);
    check("sb_lat", lat, 3);
    check("sb_den_done", 32'(den1), 0);
    check("sb_rdata_kept", rdata1, 32'h55667788);
    idle(4);

    run_access(`EXE_SW_OP, 32'h0000_0301, 32'h12345678);
    check("sw_mis_lat", lat, 1);
    check("sw_mis_err", 32'(err_seen), 1);
    check("sw_mis_ce", n_ce, 0);
    check("sw_mis_we", n_we, 0);
    check("sw_mis_den", n_den, 0);
    check("sw_mis_rdata", rdata1, 32'h55667788);
    check("sw_mis_err_clr", 32'(err_after), 0);
    idle(6);

    ALU_OP = `EXE_LW_OP; ADDR = 32'h20;
    SRAM_DIN = 32'hCAFE0001; REQ_VALID = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge CLK); #2;
      if (done3) dq.push_back(k);
      if (k == 5) check("b2b_stall_done", 32'(stall3), 0);
      if (k == 6) begin
        check("b2b_idle_ce", 32'(ce3), 1);
        check("b2b_idle_stall", 32'(stall3), 1);
      end
      if (k == 7) check("b2b_acc_ce", 32'(ce3), 0);
    end
    check("b2b_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("b2b_d0", dq[0], 5);
      check("b2b_d1", dq[1], 11);
      check("b2b_d2", dq[2], 17);
    end
    check("b2b_rdata", rdata3, 32'hCAFE0001);
    idle(8);

    ALU_OP = `EXE_LW_OP; ADDR = 32'h30;
    SRAM_DIN = 32'h0BADF00D; REQ_VALID = 1'b1; #1;
    @(posedge CLK); #2;
    REQ_VALID = 1'b0;
    @(posedge CLK); #2;
    check("rst_mid_ce", 32'(ce1), 0);
    RST = 1'b1; #1;
    check("rst_mid_stall", 32'(stall1), 0);
    @(posedge CLK); #2;
    check("rst_mid_pins", {ce1, oe1, we1, den1}, 4'b1110);
    check("rst_mid_be_n", ben1, 4'hf);
    check("rst_mid_rdata", rdata1, 0);
    check("rst_mid_done", 32'(done1), 0);
    RST = 1'b0;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #2;
      if (done1) ndone++;
    end
    check("rst_mid_nodone", ndone, 0);
    check("rst_mid_stall2", 32'(stall1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
